run_detect_p: RTL and testbench
===============================

RUN_DETECT_P -- requirements
Module: run_detect_p

Interface
REQ-001 SHALL have parameter MAX_RUN, default 4, meaning the longest run the counter tracks and the saturation value; the legal range is 2..255.
REQ-002 SHALL have localparam CNT_W = $clog2(MAX_RUN+1), meaning the run counter and threshold width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: sample-valid; w is consumed only in cycles where en=1.
REQ-006 SHALL have port clr, input, 1 bit: synchronous run clear.
REQ-007 SHALL have port w, input, 1 bit: serial data bit.
REQ-008 SHALL have port thr, input, CNT_W bits: run-length threshold.
REQ-009 SHALL have port mode, input, 2 bits: 00 detect both polarities, 01 zeros only, 10 ones only, 11 detection disabled.
REQ-010 SHALL have port q, output, 1 bit: qualified run detected.
REQ-011 SHALL have port q0, output, 1 bit: zero-run detected.
REQ-012 SHALL have port q1, output, 1 bit: one-run detected.
REQ-013 SHALL have port run_cnt, output, CNT_W bits: current saturating run length.
REQ-014 SHALL have port evt, output, 1 bit: one-cycle pulse on the rising edge of q.

Function
REQ-015 SHALL hold state in registers cnt (CNT_W bits), lastbit (1 bit) and q_d (1 bit).
REQ-016 SHALL, on an en=1 cycle with cnt==0 or w!=lastbit, load cnt=1 and lastbit=w.
REQ-017 SHALL, on an en=1 cycle with cnt!=0 and w==lastbit, set cnt=min(cnt+1, MAX_RUN), so cnt saturates and never wraps.
REQ-018 SHALL hold cnt and lastbit unchanged on en=0 cycles.
REQ-019 SHALL, on clr=1, set cnt=0 and hold lastbit; clr takes priority over en in the same cycle.
REQ-020 SHALL compute thr_eff = 1 when thr==0, MAX_RUN when thr>MAX_RUN, and thr otherwise.
REQ-021 SHALL drive hit = (cnt >= thr_eff) and (cnt != 0).
REQ-022 SHALL drive q0 = hit & ~lastbit & (mode==00 or mode==01).
REQ-023 SHALL drive q1 = hit & lastbit & (mode==00 or mode==10).
REQ-024 SHALL drive q = q0 | q1.
REQ-025 SHALL derive q, q0, q1, run_cnt and evt combinationally from registers and thr/mode only, never from w, en or clr (Moore style).
REQ-026 SHALL give a latency of one edge: q asserts in the cycle after the en=1 edge at which cnt reaches thr_eff.
REQ-027 SHALL, when thr or mode changes, update q in the same cycle without altering cnt.
REQ-028 SHALL register q_d <= q every cycle and drive evt = q & ~q_d.
REQ-029 SHALL, on a polarity flip during a run, drop q in the next cycle; with thr_eff==1 q stays high and evt does not re-fire.

Reset
REQ-030 SHALL, on Reset=1 at any time (including mid-run), immediately set cnt=0, lastbit=0 and q_d=0.
REQ-031 SHALL hold outputs during and after reset at q=q0=q1=0, run_cnt=0, evt=0, until the first en=1 edge.

Configuration
REQ-032 SHALL, with macro RUN_DETECT_EVTCNT_EN defined, add output evt_cnt (8 bits) and an internal register counting evt pulses.
REQ-033 SHALL make evt_cnt saturate at 255, reset to 0 on Reset and clear to 0 on clr.
REQ-034 SHALL, with RUN_DETECT_EVTCNT_EN undefined, omit both the evt_cnt port and its register, with all other behaviour identical.

Verification (MAX_RUN=4 unless noted)
REQ-035 SHALL cover: thr=4, mode=00, en=1, w=0,0,0,0 -> run_cnt 1,2,3,4; q=q0=1 after the 4th edge; evt high exactly one cycle.
REQ-036 SHALL cover: thr=4, w=1,1,1,0,1,1,1,1 -> q stays 0 until after the 8th edge, then q1=1 and q0=0.
REQ-037 SHALL cover: a 6-bit run of 1s -> run_cnt saturates at 4, q1 stays 1; with mode=01, q=0 throughout.
REQ-038 SHALL cover: en toggling 1,0,1,0 with w=0 -> run_cnt increments only on en=1 edges; clr=en=1 -> run_cnt=0 next cycle.
REQ-039 SHALL cover: Reset pulsed while run_cnt=3 -> outputs 0 immediately; thr=0 with a single w=1 -> q1=1 after one edge.
REQ-040 SHALL cover, with RUN_DETECT_EVTCNT_EN defined: 300 alternating 4-bit runs -> evt_cnt=255 and held.

Source files
------------

// File: rtl/run_detect_p.sv
// run_detect_p: serial run-length detector.
//
// Tracks the length of the current run of identical bits on w (sampled only
// when en=1), saturating at MAX_RUN. A run is "qualified" once its length
// reaches the effective threshold; polarity filtering is selected by mode.
// All detector outputs are Moore outputs of the registered state plus the
// live thr/mode inputs.
//
// Optional feature: define RUN_DETECT_EVTCNT_EN to add an 8-bit saturating
// count of evt pulses on port evt_cnt (cleared by Reset and by clr).
//
// Ports:
//   clk      - clock, rising edge
//   Reset    - asynchronous active-high reset
//   en       - sample valid for w
//   clr      - synchronous run clear (wins over en)
//   w        - serial data bit
//   thr      - run-length threshold (0 -> 1, >MAX_RUN -> MAX_RUN)
//   mode     - 00 both polarities, 01 zeros only, 10 ones only, 11 disabled
//   q        - qualified run detected (q0 | q1)
//   q0       - zero-run detected
//   q1       - one-run detected
//   run_cnt  - current saturating run length
//   evt      - one-cycle pulse on rising edge of q
//   evt_cnt  - (RUN_DETECT_EVTCNT_EN only) saturating evt pulse count
module run_detect_p #(
    parameter int MAX_RUN = 4,
    localparam int CNT_W  = $clog2(MAX_RUN + 1)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             en,
    input  logic             clr,
    input  logic             w,
    input  logic [CNT_W-1:0] thr,
    input  logic [1:0]       mode,
    output logic             q,
    output logic             q0,
    output logic             q1,
    output logic [CNT_W-1:0] run_cnt,
`ifdef RUN_DETECT_EVTCNT_EN
    output logic [7:0]       evt_cnt,
`endif
    output logic             evt
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RUN);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             lastbit;
    logic             q_d;
    logic [CNT_W-1:0] thr_eff;
    logic             hit;

    // Run tracking. A new run starts when nothing is tracked yet (cnt==0,
    // e.g. after reset or clr) or the polarity flips.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt     <= '0;
            lastbit <= 1'b0;
            q_d     <= 1'b0;
        end else begin
            q_d <= q;
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                if (cnt == '0 || w != lastbit) begin
                    cnt     <= ONE_C;
                    lastbit <= w;
                end else if (cnt != MAX_C) begin
                    cnt <= cnt + ONE_C;
                end
            end
        end
    end

    // Clamp threshold into 1..MAX_RUN so a saturated counter can always hit.
    always_comb begin
        if (thr == '0)
            thr_eff = ONE_C;
        else if (thr > MAX_C)
            thr_eff = MAX_C;
        else
            thr_eff = thr;
    end

    assign hit     = (cnt >= thr_eff) && (cnt != '0);
    assign q0      = hit & ~lastbit & (mode == 2'b00 || mode == 2'b01);
    assign q1      = hit &  lastbit & (mode == 2'b00 || mode == 2'b10);
    assign q       = q0 | q1;
    assign run_cnt = cnt;
    assign evt     = q & ~q_d;

`ifdef RUN_DETECT_EVTCNT_EN
    logic [7:0] evt_cnt_r;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            evt_cnt_r <= 8'd0;
        else if (clr)
            evt_cnt_r <= 8'd0;
        else if (evt && evt_cnt_r != 8'hFF)
            evt_cnt_r <= evt_cnt_r + 8'd1;
    end

    assign evt_cnt = evt_cnt_r;
`endif

endmodule

// File: tb/tb_run_detect_p.sv
// Scoreboard bench for run_detect_p. The stimulus process drives one cycle
// at a time, predicts that cycle's outputs from a history-based reference
// model and queues them; the monitor pops and compares on each falling edge.
module tb_run_detect_p;

    localparam int MAX_RUN = 4;
    localparam int CNT_W   = $clog2(MAX_RUN + 1);

    typedef struct packed {
        logic [7:0]       ec;
        logic [CNT_W-1:0] rc;
        logic             q;
        logic             q0;
        logic             q1;
        logic             evt;
    } obs_t;

    logic             clk;
    logic             Reset;
    logic             en;
    logic             clr;
    logic             w;
    logic [CNT_W-1:0] thr;
    logic [1:0]       mode;
    logic             q;
    logic             q0;
    logic             q1;
    logic [CNT_W-1:0] run_cnt;
    logic             evt;
`ifdef RUN_DETECT_EVTCNT_EN
    logic [7:0]       evt_cnt;
`endif

    run_detect_p #(.MAX_RUN(MAX_RUN)) dut (
        .clk     (clk),
        .Reset   (Reset),
        .en      (en),
        .clr     (clr),
        .w       (w),
        .thr     (thr),
        .mode    (mode),
        .q       (q),
        .q0      (q0),
        .q1      (q1),
        .run_cnt (run_cnt),
`ifdef RUN_DETECT_EVTCNT_EN
        .evt_cnt (evt_cnt),
`endif
        .evt     (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and counters (written only by the monitor).
    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   done   = 0;

    // Reference model: the accepted bits since the last clear/reset. Only
    // the trailing MAX_RUN bits can matter, so older ones are dropped.
    bit   hist[$];
    bit   m_qprev = 0;
    int   m_ec    = 0;

    function automatic int run_len();
        int n;
        bit p;
        n = 0;
        if (hist.size() == 0) return 0;
        p = hist[hist.size()-1];
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == p) n++;
            else break;
        end
        return n;
    endfunction

    // Drive one cycle's inputs just after the rising edge, predict what the
    // DUT shows during this cycle, then advance the model across the next edge.
    task automatic step(input bit e, input bit c, input bit b, input int t,
                        input int m, input bit r);
        int   len, te;
        bit   pol, hitm, e0, e1, eq, ev;
        obs_t x;
        @(posedge clk);
        #1;
        en    = e;
        clr   = c;
        w     = b;
        thr   = CNT_W'(t);
        mode  = 2'(m);
        Reset = r;
        if (r) begin
            hist.delete();
            m_qprev = 0;
            m_ec    = 0;
        end
        len  = run_len();
        pol  = (len != 0) ? hist[hist.size()-1] : 1'b0;
        te   = (t == 0) ? 1 : ((t > MAX_RUN) ? MAX_RUN : t);
        hitm = (len != 0) && (len >= te);
        e0   = hitm && !pol && (m == 0 || m == 1);
        e1   = hitm &&  pol && (m == 0 || m == 2);
        eq   = e0 || e1;
        ev   = eq && !m_qprev;
        x.rc  = CNT_W'(len);
        x.q   = eq;
        x.q0  = e0;
        x.q1  = e1;
        x.evt = ev;
`ifdef RUN_DETECT_EVTCNT_EN
        x.ec  = 8'(m_ec);
`else
        x.ec  = 8'd0;
`endif
        sb.push_back(x);
        if (!r) begin
            m_qprev = eq;
            if (c) m_ec = 0;
            else if (ev && m_ec < 255) m_ec++;
            if (c) begin
                hist.delete();
            end else if (e) begin
                hist.push_back(b);
                while (hist.size() > MAX_RUN) void'(hist.pop_front());
            end
        end
    endtask

    task automatic idle(input int n, input int t, input int m);
        for (int i = 0; i < n; i++) step(0, 0, 0, t, m, 0);
    endtask

    // Monitor: compare every cycle's outputs against the queued prediction.
    always @(negedge clk) begin
        obs_t a;
        obs_t x;
        cyc++;
        if (sb.size() > 0) begin
            x = sb.pop_front();
`ifdef RUN_DETECT_EVTCNT_EN
            a.ec = evt_cnt;
`else
            a.ec = 8'd0;
`endif
            a.rc  = run_cnt;
            a.q   = q;
            a.q0  = q0;
            a.q1  = q1;
            a.evt = evt;
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL cycle%0d outputs: got run_cnt=%0d q=%b q0=%b q1=%b evt=%b ec=%0d, want run_cnt=%0d q=%b q0=%b q1=%b evt=%b ec=%0d",
                         cyc, a.rc, a.q, a.q0, a.q1, a.evt, a.ec,
                         x.rc, x.q, x.q0, x.q1, x.evt, x.ec);
            end
        end else if (done) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d pending, want 0", sb.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        w     = 1'b0;
        thr   = '0;
        mode  = 2'b00;

        // Reset state
        step(0, 0, 0, 4, 0, 1);
        step(1, 0, 1, 4, 0, 1);
        step(0, 0, 0, 4, 0, 0);

        // Four zeros at thr=4
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4, 0, 0);
        idle(3, 4, 0);

        // 1,1,1,0,1,1,1,1
        step(0, 1, 0, 4, 0, 0);
        begin
            bit [7:0] pat;
            pat = 8'b1111_0111;
            for (int i = 0; i < 8; i++) step(1, 0, pat[i], 4, 0, 0);
        end
        idle(2, 4, 0);

        // Six ones: saturation, then same run viewed through mode=01
        step(0, 1, 0, 4, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 4, 0, 0);
        idle(1, 4, 1);
        idle(1, 4, 0);
        step(0, 1, 0, 4, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 4, 1, 0);

        // en toggling, then clr together with en
        step(0, 1, 0, 4, 0, 0);
        for (int i = 0; i < 4; i++) step((i % 2) == 0, 0, 0, 4, 0, 0);
        step(1, 1, 0, 4, 0, 0);
        idle(2, 4, 0);

        // Reset mid-run at run_cnt=3, then thr=0 with a single one
        for (int i = 0; i < 3; i++) step(1, 0, 0, 4, 0, 0);
        step(1, 0, 0, 4, 0, 1);
        step(0, 0, 0, 4, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        idle(2, 0, 0);

        // Polarity flip at thr=1 (q stays high, no new evt) and thr=4
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        idle(1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 4, 0, 0);
        step(1, 0, 0, 4, 0, 0);
        idle(1, 4, 0);

        // Threshold / mode changes without new samples
        for (int t = 0; t < 8; t++) idle(1, t, t % 4);

        // 300 alternating 4-bit runs: one evt per run, evt_cnt saturates
        step(0, 1, 0, 4, 0, 0);
        for (int r = 0; r < 300; r++)
            for (int i = 0; i < 4; i++) step(1, 0, r % 2, 4, 0, 0);
        idle(3, 4, 0);

        // Randomized traffic with run-biased data
        begin
            bit cur;
            cur = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 99) < 20) cur = ~cur;
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 39) == 0,
                     cur,
                     $urandom_range(0, 7),
                     ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(0, 3),
                     $urandom_range(0, 199) == 0);
            end
        end
        idle(2, 4, 0);

        @(posedge clk);
        done = 1;
    end

endmodule
